program_memory: RTL and testbench

//  Read-only instruction store for the single-cycle CPU datapath.
//  - Holds a fixed 32-entry x 32-bit program.
//  - Returns the word selected by prog_addr (word index, not byte address) one clock later.
//  - Sits between the PC/fetch logic and the decoder.
//  - Contents are hard-coded in RTL; entries beyond the program hold a HALT word.

---
 rtl/program_memory.sv | 72 +++++++
 tb/tb_program_memory.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// 32 x 32-bit instruction store with a one-cycle registered read and an asynchronous active-low reset.
// Define PROG_MEM_LOAD_EN to hold the image in a writable register array with load ports.
module program_memory #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'h0000_0055
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PROG_MEM_LOAD_EN
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
`endif
    input  logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] instruction
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Boot image; every address outside the program returns HALT_WORD.
    function automatic logic [DATA_W-1:0] rom_image(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] word;
        case (addr)
            ADDR_W'(0): word = DATA_W'(32'h0000_147F);
            ADDR_W'(1): word = DATA_W'(32'h0000_44FF);
            ADDR_W'(2): word = DATA_W'(32'h0000_0000);
            ADDR_W'(3): word = DATA_W'(32'h0094_00B3);
            ADDR_W'(4): word = DATA_W'(32'h4094_0133);
            ADDR_W'(5): word = DATA_W'(32'h0094_61B3);
            ADDR_W'(6): word = DATA_W'(32'h0094_7233);
            ADDR_W'(7): word = DATA_W'(32'h0094_42B3);
            ADDR_W'(8): word = DATA_W'(32'h0000_0055);
            ADDR_W'(9): word = DATA_W'(32'h0000_0055);
            default:    word = HALT_WORD;
        endcase
        return word;
    endfunction

`ifdef PROG_MEM_LOAD_EN
    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Reset restores the boot image; loads are blocked while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= rom_image(ADDR_W'(i));
            end
        end else if (ld_en) begin
            mem_reg[ld_addr] <= ld_data;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= '0;
        end else begin
            instruction <= mem_reg[prog_addr];
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= '0;
        end else begin
            instruction <= rom_image(prog_addr);
        end
    end
`endif

endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory: expected words are queued at drive time and popped after the fetch edge.
module tb_program_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  prog_addr = '0;
    logic [31:0] instruction;
`ifdef PROG_MEM_LOAD_EN
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model_mem [32];
    logic [31:0] exp_word;
    logic [31:0] prev_word;

    program_memory #(
        .ADDR_W   (5),
        .DATA_W   (32),
        .HALT_WORD(32'h0000_0055)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef PROG_MEM_LOAD_EN
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
`endif
        .prog_addr  (prog_addr),
        .instruction(instruction)
    );

    always #5 clk = ~clk;

    task automatic load_image();
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0000_0055;
        model_mem[0] = 32'h0000_147F;
        model_mem[1] = 32'h0000_44FF;
        model_mem[2] = 32'h0000_0000;
        model_mem[3] = 32'h0094_00B3;
        model_mem[4] = 32'h4094_0133;
        model_mem[5] = 32'h0094_61B3;
        model_mem[6] = 32'h0094_7233;
        model_mem[7] = 32'h0094_42B3;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        prog_addr = 5'd3;
        #1;
        tests_run++;
        if (instruction !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async_clear: got %h expected %h", instruction, 32'h0);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (instruction !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", c, instruction, 32'h0);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(model_mem[3]);
        @(posedge clk); #1;
        exp_word = exp_q.pop_front();
        tests_run++;
        if (instruction !== exp_word || instruction !== 32'h0094_00B3) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: got %h expected %h", instruction, 32'h0094_00B3);
        end
        $display("[TB] test_reset: first fetch %h", instruction);
    endtask

    task automatic test_sweep();
        prev_word = instruction;
        for (int a = 0; a < 10; a++) begin
            @(negedge clk);
            prog_addr = 5'(a);
            exp_q.push_back(model_mem[a]);
            #1;
            tests_run++;
            if (instruction !== prev_word) begin
                tests_failed++;
                $display("FAIL sweep_between_edges addr %0d: got %h expected %h", a, instruction, prev_word);
            end
            @(posedge clk); #1;
            exp_word = exp_q.pop_front();
            tests_run++;
            if (instruction !== exp_word) begin
                tests_failed++;
                $display("FAIL sweep addr %0d: got %h expected %h", a, instruction, exp_word);
            end
            $display("[TB] sweep addr %0d -> %h", a, instruction);
            prev_word = exp_word;
        end
    endtask

    task automatic test_halt_fill();
        logic [4:0] addrs [3];
        addrs[0] = 5'd10; addrs[1] = 5'd20; addrs[2] = 5'd31;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            prog_addr = addrs[k];
            exp_q.push_back(32'h0000_0055);
            @(posedge clk); #1;
            exp_word = exp_q.pop_front();
            tests_run++;
            if (instruction !== exp_word) begin
                tests_failed++;
                $display("FAIL halt_fill addr %0d: got %h expected %h", addrs[k], instruction, exp_word);
            end
            $display("[TB] halt addr %0d -> %h", addrs[k], instruction);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] a;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            a = 5'($urandom_range(0, 31));
            prog_addr = a;
            exp_q.push_back(model_mem[a]);
            @(posedge clk); #1;
            exp_word = exp_q.pop_front();
            tests_run++;
            if (instruction !== exp_word) begin
                tests_failed++;
                $display("FAIL back_to_back addr %0d: got %h expected %h", a, instruction, exp_word);
            end
            $display("[TB] b2b addr %0d -> %h", a, instruction);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        prog_addr = 5'd4;
        exp_q.push_back(model_mem[4]);
        @(posedge clk); #1;
        exp_word = exp_q.pop_front();
        tests_run++;
        if (instruction !== exp_word || instruction !== 32'h4094_0133) begin
            tests_failed++;
            $display("FAIL async_pre: got %h expected %h", instruction, 32'h4094_0133);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (instruction !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_drop: got %h expected %h", instruction, 32'h0);
        end
        @(posedge clk); #1;
        tests_run++;
        if (instruction !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_hold: got %h expected %h", instruction, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(model_mem[4]);
        @(posedge clk); #1;
        exp_word = exp_q.pop_front();
        tests_run++;
        if (instruction !== exp_word) begin
            tests_failed++;
            $display("FAIL async_recover: got %h expected %h", instruction, exp_word);
        end
        $display("[TB] async reset drop/recover -> %h", instruction);
    endtask

`ifdef PROG_MEM_LOAD_EN
    task automatic test_load();
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 5'd2; ld_data = 32'hDEAD_BEEF; prog_addr = 5'd2;
        exp_q.push_back(model_mem[2]);
        model_mem[2] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        exp_word = exp_q.pop_front();
        tests_run++;
        if (instruction !== exp_word || instruction !== 32'h0) begin
            tests_failed++;
            $display("FAIL load_rbw_old: got %h expected %h", instruction, 32'h0);
        end
        @(negedge clk);
        ld_en = 1'b0;
        exp_q.push_back(model_mem[2]);
        @(posedge clk); #1;
        exp_word = exp_q.pop_front();
        tests_run++;
        if (instruction !== exp_word) begin
            tests_failed++;
            $display("FAIL load_new: got %h expected %h", instruction, exp_word);
        end
        // Load attempted during reset must be ignored; reset also restores the image.
        @(negedge clk);
        reset = 1'b0; ld_en = 1'b1; ld_addr = 5'd2; ld_data = 32'h1234_5678;
        @(posedge clk); #1;
        tests_run++;
        if (instruction !== 32'h0) begin
            tests_failed++;
            $display("FAIL load_reset_hold: got %h expected %h", instruction, 32'h0);
        end
        @(negedge clk);
        ld_en = 1'b0; reset = 1'b1;
        load_image();
        exp_q.push_back(model_mem[2]);
        @(posedge clk); #1;
        exp_word = exp_q.pop_front();
        tests_run++;
        if (instruction !== exp_word) begin
            tests_failed++;
            $display("FAIL load_reload: got %h expected %h", instruction, exp_word);
        end
        $display("[TB] load/reload addr 2 -> %h", instruction);
    endtask
`endif

    initial begin
        load_image();
        test_reset();
        test_sweep();
        test_halt_fill();
        test_back_to_back();
        test_async_reset();
`ifdef PROG_MEM_LOAD_EN
        test_load();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
